// File: rtl/spiflash_emu.sv
// SPI flash emulator: oversamples the flash pins on the system clock and serves
// 03/0B single-bit and EB quad reads (with continuous-read mode) from a loadable byte memory.
module spiflash_emu #(
  parameter int unsigned ADDR_BITS   = 16,
  parameter int unsigned LATENCY     = 8,
  parameter int unsigned FAST_DUMMY  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 flash_csb,
  input  logic                 flash_clk,
  input  logic [3:0]           flash_io_di,
  output logic [3:0]           flash_io_do,
  output logic [3:0]           flash_io_oe,
  input  logic                 load_valid,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [7:0]           load_data,
  output logic                 load_ready,
  output logic                 powered_up,
  output logic                 xip_active
);

  localparam int unsigned DEPTH   = 1 << ADDR_BITS;
  localparam int unsigned PIN_W   = 6;
  localparam int unsigned DUMMY_W = 8;

  localparam logic [7:0] OP_READ   = 8'h03;
  localparam logic [7:0] OP_FAST   = 8'h0B;
  localparam logic [7:0] OP_QREAD  = 8'hEB;
  localparam logic [7:0] OP_WAKE   = 8'hAB;
  localparam logic [7:0] OP_SLEEP  = 8'hB9;
  localparam logic [7:0] OP_RSTXIP = 8'hFF;
  localparam logic [7:0] XIP_MODE  = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_MODE,
    S_DUMMY,
    S_DATA,
    S_IGNORE
  } state_e;

  // Pin synchroniser; each stage holds {csb, clk, io[3:0]}, csb idles high
  logic [SYNC_STAGES-1:0][PIN_W-1:0] sync_q, sync_d;
  logic [PIN_W-1:0] pins_s;
  logic             csb_s, sclk_s;
  logic [3:0]       io_s;

  logic sclk_prev_q, sclk_prev_d;
  logic csb_prev_q, csb_prev_d;
  logic sclk_rise_c, sclk_fall_c, csb_fall_c;

  state_e                 state_q, state_d;
  logic                   quad_q, quad_d;
  logic [7:0]             cmd_q, cmd_d;
  logic [23:0]            shift_q, shift_d;
  logic [4:0]             bit_cnt_q, bit_cnt_d;
  logic [DUMMY_W-1:0]     dummy_cnt_q, dummy_cnt_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [7:0]             out_sr_q, out_sr_d;
  logic [2:0]             out_cnt_q, out_cnt_d;
  logic [3:0]             io_do_q, io_do_d;
  logic [3:0]             io_oe_q, io_oe_d;
  logic                   powered_q, powered_d;
  logic                   xip_q, xip_d;
  logic                   load_ready_q, load_ready_d;

  logic [23:0]            shift_nxt_c;
  logic [ADDR_BITS-1:0]   addr_full_c;
  logic [7:0]             mem_rd_c;
  logic [7:0]             cur_byte_c;
  logic                   mem_we_c;

  logic [7:0] mem_q [DEPTH];

  assign pins_s = sync_q[SYNC_STAGES-1];
  assign csb_s  = pins_s[5];
  assign sclk_s = pins_s[4];
  assign io_s   = pins_s[3:0];

  assign sclk_rise_c = sclk_s & ~sclk_prev_q;
  assign sclk_fall_c = ~sclk_s & sclk_prev_q;
  assign csb_fall_c  = ~csb_s & csb_prev_q;

  assign shift_nxt_c = quad_q ? {shift_q[19:0], io_s} : {shift_q[22:0], io_s[0]};
  assign addr_full_c = ADDR_BITS'(shift_nxt_c);
  assign mem_rd_c    = mem_q[addr_q];
  assign mem_we_c    = load_valid & load_ready_q;

  // Memory has no reset so its contents survive resetn
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[load_addr] <= load_data;
    end
  end

  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], flash_csb, flash_clk, flash_io_di};
    sclk_prev_d  = sclk_s;
    csb_prev_d   = csb_s;
    state_d      = state_q;
    quad_d       = quad_q;
    cmd_d        = cmd_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    dummy_cnt_d  = dummy_cnt_q;
    addr_d       = addr_q;
    out_sr_d     = out_sr_q;
    out_cnt_d    = out_cnt_q;
    io_do_d      = io_do_q;
    io_oe_d      = io_oe_q;
    powered_d    = powered_q;
    xip_d        = xip_q;
    cur_byte_c   = out_sr_q;

    case (state_q)
      S_IDLE: begin
        if (csb_fall_c) begin
          bit_cnt_d = 5'd0;
          if (xip_q) begin
            state_d = S_ADDR;
            quad_d  = 1'b1;
            cmd_d   = OP_QREAD;
          end else begin
            state_d = S_CMD;
            quad_d  = 1'b0;
          end
        end
      end

      S_CMD: begin
        if (sclk_rise_c) begin
          shift_d   = shift_nxt_c;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = 5'd0;
            cmd_d     = shift_nxt_c[7:0];
            state_d   = S_IGNORE;
            case (shift_nxt_c[7:0])
              OP_WAKE:   powered_d = 1'b1;
              OP_SLEEP: begin
                powered_d = 1'b0;
                xip_d     = 1'b0;
              end
              OP_RSTXIP: xip_d = 1'b0;
              OP_READ, OP_FAST: begin
                if (powered_q) begin
                  state_d = S_ADDR;
                  quad_d  = 1'b0;
                end
              end
              OP_QREAD: begin
                if (powered_q) begin
                  state_d = S_ADDR;
                  quad_d  = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      end

      S_ADDR: begin
        if (sclk_rise_c) begin
          shift_d   = shift_nxt_c;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == (quad_q ? 5'd5 : 5'd23)) begin
            bit_cnt_d = 5'd0;
            addr_d    = addr_full_c;
            case (cmd_q)
              OP_READ: begin
                state_d   = S_DATA;
                out_cnt_d = 3'd0;
                io_oe_d   = 4'h2;
              end
              OP_FAST: begin
                state_d     = S_DUMMY;
                dummy_cnt_d = DUMMY_W'(FAST_DUMMY);
              end
              default: state_d = S_MODE;
            endcase
          end
        end
      end

      S_MODE: begin
        if (sclk_rise_c) begin
          shift_d   = shift_nxt_c;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd1) begin
            bit_cnt_d   = 5'd0;
            xip_d       = (shift_nxt_c[7:0] == XIP_MODE);
            state_d     = S_DUMMY;
            dummy_cnt_d = DUMMY_W'(LATENCY);
          end
        end
      end

      // Leaves as soon as the count is exhausted, well before the next SPI falling edge
      S_DUMMY: begin
        if (dummy_cnt_q == '0) begin
          state_d   = S_DATA;
          out_cnt_d = 3'd0;
          io_oe_d   = quad_q ? 4'hF : 4'h2;
        end else if (sclk_rise_c) begin
          dummy_cnt_d = dummy_cnt_q - DUMMY_W'(1);
        end
      end

      // A fresh byte is pulled from memory whenever the previous one is fully shifted
      S_DATA: begin
        if (sclk_fall_c) begin
          if (out_cnt_q == 3'd0) begin
            cur_byte_c = mem_rd_c;
            addr_d     = addr_q + ADDR_BITS'(1);
          end
          if (quad_q) begin
            io_do_d   = cur_byte_c[7:4];
            out_sr_d  = {cur_byte_c[3:0], 4'h0};
            out_cnt_d = (out_cnt_q == 3'd1) ? 3'd0 : out_cnt_q + 3'd1;
          end else begin
            io_do_d   = {2'b00, cur_byte_c[7], 1'b0};
            out_sr_d  = {cur_byte_c[6:0], 1'b0};
            out_cnt_d = out_cnt_q + 3'd1;
          end
        end
      end

      S_IGNORE: ;

      default: state_d = S_IDLE;
    endcase

    // Deselect aborts any frame
    if (csb_s) begin
      state_d     = S_IDLE;
      bit_cnt_d   = 5'd0;
      dummy_cnt_d = '0;
      out_cnt_d   = 3'd0;
      io_oe_d     = 4'h0;
      io_do_d     = 4'h0;
    end

    load_ready_d = (state_d == S_IDLE) && csb_s;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q       <= {SYNC_STAGES{6'h20}};
      sclk_prev_q  <= 1'b0;
      csb_prev_q   <= 1'b1;
      state_q      <= S_IDLE;
      quad_q       <= 1'b0;
      cmd_q        <= 8'h00;
      shift_q      <= 24'h0;
      bit_cnt_q    <= 5'd0;
      dummy_cnt_q  <= '0;
      addr_q       <= '0;
      out_sr_q     <= 8'h00;
      out_cnt_q    <= 3'd0;
      io_do_q      <= 4'h0;
      io_oe_q      <= 4'h0;
      powered_q    <= 1'b0;
      xip_q        <= 1'b0;
      load_ready_q <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      sclk_prev_q  <= sclk_prev_d;
      csb_prev_q   <= csb_prev_d;
      state_q      <= state_d;
      quad_q       <= quad_d;
      cmd_q        <= cmd_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      dummy_cnt_q  <= dummy_cnt_d;
      addr_q       <= addr_d;
      out_sr_q     <= out_sr_d;
      out_cnt_q    <= out_cnt_d;
      io_do_q      <= io_do_d;
      io_oe_q      <= io_oe_d;
      powered_q    <= powered_d;
      xip_q        <= xip_d;
      load_ready_q <= load_ready_d;
    end
  end

  assign flash_io_do = io_do_q;
  assign flash_io_oe = io_oe_q;
  assign load_ready  = load_ready_q;
  assign powered_up  = powered_q;
  assign xip_active  = xip_q;

endmodule

// File: tb/tb_spiflash_emu.sv
// Bench for spiflash_emu: bit-banged SPI master with a byte-array/flag model of the flash.
module tb_spiflash_emu;

  localparam int unsigned ADDR_BITS  = 16;
  localparam int unsigned LATENCY    = 8;
  localparam int unsigned FAST_DUMMY = 8;
  localparam int unsigned DEPTH      = 1 << ADDR_BITS;
  localparam int          H          = 6;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic                 flash_csb;
  logic                 flash_clk;
  logic [3:0]           flash_io_di;
  logic [3:0]           flash_io_do;
  logic [3:0]           flash_io_oe;
  logic                 load_valid;
  logic [ADDR_BITS-1:0] load_addr;
  logic [7:0]           load_data;
  logic                 load_ready;
  logic                 powered_up;
  logic                 xip_active;

  always #5 clk = ~clk;

  spiflash_emu #(
    .ADDR_BITS  (ADDR_BITS),
    .LATENCY    (LATENCY),
    .FAST_DUMMY (FAST_DUMMY),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flash_csb  (flash_csb),
    .flash_clk  (flash_clk),
    .flash_io_di(flash_io_di),
    .flash_io_do(flash_io_do),
    .flash_io_oe(flash_io_oe),
    .load_valid (load_valid),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_ready (load_ready),
    .powered_up (powered_up),
    .xip_active (xip_active)
  );

  // Reference model: flash contents plus the two mode flags
  logic [7:0]  model_mem [DEPTH];
  bit          powered_m = 1'b0;
  bit          xip_m     = 1'b0;
  int          n_tests   = 0;
  int          n_fail    = 0;
  int unsigned oe_cycles = 0;

  always @(posedge clk) if (flash_io_oe != 4'h0) oe_cycles <= oe_cycles + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic half();
    repeat (H) @(negedge clk);
  endtask

  task automatic load_byte(input logic [ADDR_BITS-1:0] a, input logic [7:0] d);
    int t = 0;
    @(negedge clk);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    while (load_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("load_ready", load_ready, 1);
    @(posedge clk);
    #1 load_valid = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic spi_start();
    flash_clk = 1'b0;
    flash_csb = 1'b0;
    half();
    chk("ldrdy_busy", load_ready, 0);
  endtask

  task automatic spi_end();
    flash_clk = 1'b0;
    half();
    flash_csb = 1'b1;
    repeat (2 * H) @(negedge clk);
  endtask

  task automatic send_bits(input logic [23:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      flash_clk   = 1'b0;
      flash_io_di = {3'b000, v[i]};
      half();
      flash_clk = 1'b1;
      half();
    end
  endtask

  task automatic send_quad(input logic [23:0] v, input int nib);
    for (int i = nib - 1; i >= 0; i--) begin
      flash_clk   = 1'b0;
      flash_io_di = v[4*i +: 4];
      half();
      flash_clk = 1'b1;
      half();
    end
  endtask

  task automatic dummies(input int n, inout int bad);
    for (int i = 0; i < n; i++) begin
      flash_clk = 1'b0;
      half();
      if (flash_io_oe != 4'h0) bad++;
      flash_clk = 1'b1;
      half();
    end
  endtask

  task automatic read_byte(input bit q, output logic [7:0] b, output logic [3:0] oe0);
    b   = 8'h00;
    oe0 = 4'h0;
    for (int i = 0; i < (q ? 2 : 8); i++) begin
      flash_clk = 1'b0;
      half();
      if (i == 0) oe0 = flash_io_oe;
      b = q ? {b[3:0], flash_io_do} : {b[6:0], flash_io_do[1]};
      flash_clk = 1'b1;
      half();
    end
  endtask

  task automatic cmd_frame(input logic [7:0] op);
    spi_start();
    send_bits({16'h0, op}, 8);
    spi_end();
    if (op == 8'hAB) powered_m = 1'b1;
    if (op == 8'hB9) begin
      powered_m = 1'b0;
      xip_m     = 1'b0;
    end
    if (op == 8'hFF) xip_m = 1'b0;
    chk("powered", powered_up, powered_m);
    chk("xip_cmd", xip_active, xip_m);
  endtask

  task automatic read_frame(input logic [7:0] op, input logic [23:0] a, input int n,
                            input logic [7:0] mode);
    logic [7:0] b;
    logic [3:0] oe0;
    logic [7:0] eff_op;
    int         bad = 0;
    bit         q;
    bit         ok;
    eff_op = xip_m ? 8'hEB : op;
    q      = (eff_op == 8'hEB);
    ok     = powered_m && (eff_op inside {8'h03, 8'h0B, 8'hEB});
    spi_start();
    if (!xip_m) send_bits({16'h0, op}, 8);
    if (q) send_quad(a, 6);
    else   send_bits(a, 24);
    if (eff_op == 8'h0B) dummies(FAST_DUMMY, bad);
    if (q) begin
      send_quad({16'h0, mode}, 2);
      dummies(LATENCY, bad);
    end
    chk("dummy_oe", bad, 0);
    for (int i = 0; i < n; i++) begin
      read_byte(q, b, oe0);
      chk("rd_oe", oe0, ok ? (q ? 4'hF : 4'h2) : 4'h0);
      if (ok) chk("rd_data", b, model_mem[(int'(a) + i) % DEPTH]);
    end
    spi_end();
    chk("end_oe", flash_io_oe, 0);
    if (ok && q) xip_m = (mode == 8'hA5);
    chk("xip", xip_active, xip_m);
  endtask

  function automatic logic [15:0] win_addr();
    if ($urandom_range(0, 1) == 1) return 16'($urandom_range(0, 40));
    return 16'($urandom_range(16'hFFF0, 16'hFFFD));
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  b;
    logic [3:0]  oe0;
    int unsigned oe_snap;
    logic [7:0]  mode;
    logic [23:0] a;
    int          kind;

    resetn      = 1'b0;
    flash_csb   = 1'b1;
    flash_clk   = 1'b0;
    flash_io_di = 4'h0;
    load_valid  = 1'b0;
    load_addr   = '0;
    load_data   = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_oe", flash_io_oe, 0);
    chk("rst_do", flash_io_do, 0);
    chk("rst_pwr", powered_up, 0);
    chk("rst_xip", xip_active, 0);
    chk("rst_ldrdy", load_ready, 0);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_ldrdy", load_ready, 1);

    // 1: plain read of a counting pattern
    for (int i = 0; i < 16; i++) load_byte(16'(i), 8'(i));
    cmd_frame(8'hAB);
    read_frame(8'h03, 24'h000004, 4, 8'h00);

    // 2: reads while powered down produce nothing
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn    = 1'b1;
    powered_m = 1'b0;
    xip_m     = 1'b0;
    repeat (4) @(negedge clk);
    oe_snap = oe_cycles;
    read_frame(8'h03, 24'h000000, 2, 8'h00);
    cmd_frame(8'hAB);
    cmd_frame(8'hB9);
    read_frame(8'h03, 24'h000000, 2, 8'h00);
    chk("t2_oe_quiet", oe_cycles - oe_snap, 0);

    // 3: fast read with dummy clocks
    cmd_frame(8'hAB);
    read_frame(8'h0B, 24'h000002, 2, 8'h00);

    // 4: quad read, continuous mode arm / reuse / disarm
    read_frame(8'hEB, 24'h000008, 2, 8'hA5);
    read_frame(8'hEB, 24'h00000C, 1, 8'hA5);
    read_frame(8'hEB, 24'h000003, 1, 8'h00);

    // 5: address wrap at the top of memory, upper address bits ignored
    load_byte(16'hFFFF, 8'hFF);
    load_byte(16'h0000, 8'h00);
    read_frame(8'h03, 24'h00FFFF, 2, 8'h00);
    read_frame(8'h03, 24'h3CFFFF, 2, 8'h00);

    // 6: reset in the middle of a data phase keeps memory
    for (int i = 0; i < 64; i++) load_byte(16'(i), 8'($urandom));
    for (int i = 0; i < 16; i++) load_byte(16'(16'hFFF0 + i), 8'($urandom));
    spi_start();
    send_bits(24'h000003, 8);
    send_bits(24'h000005, 24);
    read_byte(1'b0, b, oe0);
    chk("t6_byte", b, model_mem[5]);
    flash_clk = 1'b0;
    repeat (H / 2) @(negedge clk);
    chk("t6_pre_oe", flash_io_oe, 4'h2);
    resetn = 1'b0;
    #1;
    chk("t6_rst_oe", flash_io_oe, 0);
    chk("t6_rst_do", flash_io_do, 0);
    chk("t6_rst_pwr", powered_up, 0);
    flash_csb = 1'b1;
    powered_m = 1'b0;
    xip_m     = 1'b0;
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    cmd_frame(8'hAB);
    read_frame(8'h03, 24'h000000, 8, 8'h00);

    // Random mix of transactions against the model
    for (int k = 0; k < 14; k++) begin
      for (int j = 0; j < 3; j++) load_byte(win_addr(), 8'($urandom));
      a    = {8'($urandom), win_addr()};
      kind = int'($urandom_range(0, 4));
      mode = ($urandom_range(0, 2) == 0) ? 8'hA5 : 8'($urandom);
      case (kind)
        0: read_frame(8'h03, a, int'($urandom_range(1, 4)), 8'h00);
        1: read_frame(8'h0B, a, int'($urandom_range(1, 4)), 8'h00);
        2: read_frame(8'hEB, a, int'($urandom_range(1, 4)), mode);
        3: read_frame(8'h9F, a, 1, 8'h00);
        default: begin
          if (xip_m) read_frame(8'hEB, a, 1, 8'h00);
          cmd_frame(8'hB9);
          if ($urandom_range(0, 1) == 1) cmd_frame(8'hAB);
        end
      endcase
    end
    if (xip_m) read_frame(8'hEB, 24'h000010, 1, 8'h00);
    cmd_frame(8'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spiflash_emu.md
Name: spiflash_emu

Overview:
- Synthesizable SPI flash emulator clocked by the system clock. It lets FPGA builds and gate-level benches run the flash-boot path without an external device.
- It oversamples the pin-level SPI bus: flash_csb, flash_clk and flash_io*.
- It serves single-bit and quad reads from an internal byte memory.
- The memory is preloaded through a simple load port.
- Parametrised in memory depth, dummy-cycle latency and synchroniser depth.
- Adds 0B fast read and continuous-read (XIP) mode over the single-bit read path.

Parameters:
ADDR_BITS, 16, memory depth is 2**ADDR_BITS bytes; higher bits of the 24-bit flash address are ignored.
LATENCY, 8, dummy SPI clocks between the EB mode byte and the first data nibble.
FAST_DUMMY, 8, dummy SPI clocks between the 0B address and the first data bit.
SYNC_STAGES, 2, flip-flop stages on each SPI pin input (minimum 2).

Ports:
clk  in  1  system clock.
resetn  in  1  reset.
flash_csb  in  1  SPI chip select, active low.
flash_clk  in  1  SPI clock; frequency must be at most clk/4.
flash_io_di  in  4  pin inputs io3..io0.
flash_io_do  out  4  pin output data.
flash_io_oe  out  4  pin output enables.
load_valid  in  1  memory load request.
load_addr  in  ADDR_BITS  load byte address.
load_data  in  8  load byte.
load_ready  out  1  load accepted when high together with load_valid.
powered_up  out  1  device is awake.
xip_active  out  1  continuous-read mode is armed.

Interface (already decided):
- One clock; reset is asynchronous and active-low (clk / resetn).

Behaviour:
- Reset values: flash_io_oe=0, flash_io_do=0, powered_up=0, xip_active=0, load_ready=0; internal state IDLE.
- Input synchronisation: all pin inputs pass through SYNC_STAGES flops. SPI clock edges are detected on the synchronised flash_clk, with one extra registered stage.
  - Inputs are sampled on a detected rising edge.
  - Outputs update in the clk cycle after a detected falling edge.
- State machine: IDLE, CMD, ADDR, MODE, DUMMY, DATA, IGNORE.
- csb high (synchronised):
  - From any state, return to IDLE.
  - Bit and byte counters clear; flash_io_oe=0.
  - load_ready=1 only in IDLE with csb high.
- csb falling:
  - xip_active=0: go to CMD.
  - xip_active=1: go directly to ADDR in quad width, with command EB implied.
- CMD (8 single-bit samples on io0, MSB first):
  - AB sets powered_up=1.
  - B9 sets powered_up=0 and xip_active=0.
  - FF clears xip_active.
  - While powered_up=1:
    - 03 goes to ADDR, single width.
    - 0B goes to ADDR, single width.
    - EB goes to ADDR, quad width.
  - Any other opcode, or any read while powered down, goes to IGNORE: outputs off until csb rises.
- ADDR: 24 address bits, MSB first; single width takes 24 rising edges, quad width takes 6.
- After ADDR:
  - 03 goes to DATA.
  - 0B goes to DUMMY with FAST_DUMMY count.
  - EB goes to MODE.
- MODE (EB only): 2 quad samples.
  - xip_active = (mode byte == 8'hA5).
  - Then DUMMY with LATENCY count.
- DUMMY: outputs off; count decrements on each rising edge; go to DATA when it reaches 0.
- DATA, single width:
  - flash_io_oe=4'b0010; io1 carries the byte MSB first.
  - The first bit is driven after the first falling edge following the final address or dummy rising edge.
  - The next byte is fetched when the last bit is shifted.
- DATA, quad width:
  - flash_io_oe=4'hF; high nibble first, io3 = bit 7.
- Addressing: the address post-increments per byte, modulo 2**ADDR_BITS; wrap from the top address to 0 is silent.
- Reads stream indefinitely until csb rises.
- Load port:
  - Write memory[load_addr] <= load_data when load_valid & load_ready; one cycle per byte.
  - If load_valid coincides with a detected csb fall, the write completes that cycle and the transaction starts the next cycle.
- resetn asserted mid-transaction: immediate return to reset values. Memory contents are preserved.
- Only the rising edge of flash_clk matters in SPI mode 0; flash_clk high at the csb fall is tolerated (mode 3).

Test Plan:
1. Reset, load bytes 00..0F at 0..15, send AB then 03 000004 and read 4 bytes -> io1 returns 04 05 06 07; flash_io_oe=0 after csb rises.
2. Without AB, send 03 000000 -> oe stays 0 throughout. Then AB, B9, 03 -> still no output; powered_up reads 1 then 0.
3. AB; 0B 000002 with 8 dummy clocks -> io1 returns 02 03; oe low during dummy.
4. AB; EB, address 000008, mode A5, LATENCY dummies -> quad bytes 08 09 and xip_active=1. Next csb frame with address 00000C + A5 (no opcode) -> 0C. Then a frame with mode 00 -> xip_active=0.
5. ADDR_BITS=16, byte FF at FFFF and 00 at 0; 03 00FFFF reading 2 bytes -> FF, 00 (wrap).
6. Assert resetn low mid-DATA -> oe=0 immediately, powered_up=0. After AB + 03, the previously loaded data is read back intact.
